instruction_loader: RTL and testbench

Front-end loader that sits directly upstream of the pipeline top and drives its `i_write` / `i_instruction` inputs. It consumes bytes from the UART receiver and assembles them MSB-first into 32-bit instruction words. Each word is written into instruction memory with a single-cycle write strobe and an incrementing word-aligned address. Loading stops on a HALT word or when memory is full, and the block then reports completion to the debug logic.

---
 rtl/instruction_loader_if.sv | 31 +++
 rtl/instruction_loader.sv | 118 +++++++++++
 tb/tb_instruction_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_if.sv
// Loader-side bus: UART byte input plus the instruction-memory write port and load status.
interface instruction_loader_if #(
  parameter int INST_SZ   = 32,
  parameter int BYTE_SZ   = 8,
  parameter int ADDR_SZ   = 32,
  parameter int MEM_DEPTH = 64
);
  localparam int CNT_W = $clog2(MEM_DEPTH) + 1;

  logic [BYTE_SZ-1:0] i_rx_data;
  logic               i_rx_done;
  logic               o_write;
  logic [INST_SZ-1:0] o_instruction;
  logic [ADDR_SZ-1:0] o_inst_addr;
  logic [CNT_W-1:0]   o_inst_count;
  logic               o_busy;
  logic               o_load_done;
  logic               o_overflow;

  modport master (
    input  i_rx_data, i_rx_done,
    output o_write, o_instruction, o_inst_addr, o_inst_count,
           o_busy, o_load_done, o_overflow
  );

  modport slave (
    output i_rx_data, i_rx_done,
    input  o_write, o_instruction, o_inst_addr, o_inst_count,
           o_busy, o_load_done, o_overflow
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs MSB-first UART bytes into words and writes them to instruction memory; strobe follows the 4th-byte edge.
// No backpressure: one byte per cycle is absorbed, including the byte that lands during a write cycle.
module instruction_loader #(
  parameter int                 INST_SZ   = 32,
  parameter int                 BYTE_SZ   = 8,
  parameter int                 ADDR_SZ   = 32,
  parameter int                 MEM_DEPTH = 64,
  parameter logic [BYTE_SZ-1:0] CMD_LOAD  = 8'h4C,
  parameter logic [INST_SZ-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic                  i_clk,
  input logic                  i_reset,
  instruction_loader_if.master bus
);
  localparam int BYTES  = INST_SZ / BYTE_SZ;
  localparam int BCNT_W = $clog2(BYTES);
  localparam int CNT_W  = $clog2(MEM_DEPTH) + 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [INST_SZ-1:0]  shift_q, shift_d;
  logic [INST_SZ-1:0]  inst_q, inst_d;
  logic [ADDR_SZ-1:0]  addr_q, addr_d;
  logic                ovf_q, ovf_d;
  logic                write_q, busy_q, done_q;
  logic [INST_SZ-1:0]  shifted;

  assign shifted = {shift_q[INST_SZ-BYTE_SZ-1:0], bus.i_rx_data};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    inst_d     = inst_q;
    addr_d     = addr_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.i_rx_done && bus.i_rx_data == CMD_LOAD) begin
          state_d    = RECEIVE;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      RECEIVE: begin
        if (bus.i_rx_done) begin
          shift_d = shifted;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
            inst_d     = shifted;
            addr_d     = ADDR_SZ'({word_cnt_q, 2'b00});
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        // A byte arriving now is byte 0 of the next word; byte_cnt is 0 here so it cannot complete a word.
        if (bus.i_rx_done) begin
          shift_d    = shifted;
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
        word_cnt_d = word_cnt_q + 1'b1;
        if (inst_q == HALT_WORD) begin
          state_d = DONE;
        end else if (word_cnt_q + 1'b1 == DEPTH) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = RECEIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      inst_q     <= '0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      write_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      inst_q     <= inst_d;
      addr_q     <= addr_d;
      ovf_q      <= ovf_d;
      write_q    <= (state_d == WRITE);
      busy_q     <= (state_d == RECEIVE) || (state_d == WRITE);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.o_write       = write_q;
  assign bus.o_instruction = inst_q;
  assign bus.o_inst_addr   = addr_q;
  assign bus.o_inst_count  = word_cnt_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_load_done   = done_q;
  assign bus.o_overflow    = ovf_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench: a 64-word loader and a 4-word loader share one byte stream; write logs are compared to hand-built lists.
module tb_instruction_loader;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] wq_a[$];
  logic [63:0] wq_b[$];
  logic [63:0] exp_q[$];
  int          dbl_a = 0;
  int          dbl_b = 0;
  int          ovl_a = 0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;

  always #5 clk = ~clk;

  instruction_loader_if #(.MEM_DEPTH(64)) ifa ();
  instruction_loader_if #(.MEM_DEPTH(4))  ifb ();

  assign ifa.i_rx_data = rx_data;
  assign ifa.i_rx_done = rx_done;
  assign ifb.i_rx_data = rx_data;
  assign ifb.i_rx_done = rx_done;

  instruction_loader #(.MEM_DEPTH(64)) dut_a (.i_clk(clk), .i_reset(rst_n), .bus(ifa));
  instruction_loader #(.MEM_DEPTH(4))  dut_b (.i_clk(clk), .i_reset(rst_n), .bus(ifb));

  // Write monitor: sampled mid-cycle, logs {addr, data} and counts back-to-back strobes.
  always @(negedge clk) begin
    if (ifa.o_write) begin
      wq_a.push_back({ifa.o_inst_addr, ifa.o_instruction});
      if (prev_a) dbl_a++;
      if (rx_done) ovl_a++;
    end
    if (ifb.o_write) begin
      wq_b.push_back({ifb.o_inst_addr, ifb.o_instruction});
      if (prev_b) dbl_b++;
    end
    prev_a = ifa.o_write;
    prev_b = ifb.o_write;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    wq_a.delete();
    wq_b.delete();
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  task automatic verify_a(input string tag);
    check({tag, "_nwr_a"}, 64'(wq_a.size()), 64'(exp_q.size()));
    for (int i = 0; i < wq_a.size() && i < exp_q.size(); i++)
      check({tag, "_wr_a"}, wq_a[i], exp_q[i]);
  endtask

  task automatic verify_b(input string tag);
    check({tag, "_nwr_b"}, 64'(wq_b.size()), 64'(exp_q.size()));
    for (int i = 0; i < wq_b.size() && i < exp_q.size(); i++)
      check({tag, "_wr_b"}, wq_b[i], exp_q[i]);
  endtask

  task automatic end_case();
    exp_q.delete();
    wq_a.delete();
    wq_b.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_write"}, 64'(ifa.o_write), 64'd0);
    check({tag, "_inst"},  64'(ifa.o_instruction), 64'd0);
    check({tag, "_addr"},  64'(ifa.o_inst_addr), 64'd0);
    check({tag, "_count"}, 64'(ifa.o_inst_count), 64'd0);
    check({tag, "_busy"},  64'(ifa.o_busy), 64'd0);
    check({tag, "_done"},  64'(ifa.o_load_done), 64'd0);
    check({tag, "_ovf"},   64'(ifa.o_overflow), 64'd0);
  endtask

  initial begin
    logic [7:0] stream[$];

    // Reset state
    idle(2);
    check_zero("rst");
    check("rst_count_b", 64'(ifb.o_inst_count), 64'd0);
    rst_n = 1'b1;
    do_reset();

    // Basic load
    send_byte(8'h4C);
    check("busy_rise", 64'(ifa.o_busy), 64'd1);
    send_word(32'h20010005);
    send_word(HALT);
    idle(3);
    expect_write(32'd0, 32'h20010005);
    expect_write(32'd4, HALT);
    verify_a("basic");
    verify_b("basic");
    check("basic_count", 64'(ifa.o_inst_count), 64'd2);
    check("basic_done",  64'(ifa.o_load_done), 64'd1);
    check("basic_ovf",   64'(ifa.o_overflow), 64'd0);
    check("basic_busy",  64'(ifa.o_busy), 64'd0);
    end_case();

    // Bytes before the command are ignored
    do_reset();
    send_word(32'h11223344);
    idle(2);
    check("pre_nwr", 64'(wq_a.size()), 64'd0);
    check("pre_busy", 64'(ifa.o_busy), 64'd0);
    send_byte(8'h4C);
    send_word(32'h00000000);
    send_word(HALT);
    idle(3);
    expect_write(32'd0, 32'h00000000);
    expect_write(32'd4, HALT);
    verify_a("pre");
    end_case();

    // Overflow on the 4-word instance
    do_reset();
    send_byte(8'h4C);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    send_word(32'h55555555);
    idle(3);
    expect_write(32'd0,  32'h11111111);
    expect_write(32'd4,  32'h22222222);
    expect_write(32'd8,  32'h33333333);
    expect_write(32'd12, 32'h44444444);
    verify_b("ovf");
    check("ovf_flag_b",  64'(ifb.o_overflow), 64'd1);
    check("ovf_done_b",  64'(ifb.o_load_done), 64'd1);
    check("ovf_count_b", 64'(ifb.o_inst_count), 64'd4);
    check("ovf_count_a", 64'(ifa.o_inst_count), 64'd5);
    check("ovf_busy_a",  64'(ifa.o_busy), 64'd1);
    check("ovf_flag_a",  64'(ifa.o_overflow), 64'd0);
    end_case();

    // Back-to-back bytes, one per cycle
    do_reset();
    ovl_a = 0;
    stream = '{8'h4C, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h12, 8'h34, 8'h56, 8'h78,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (stream[i]) begin
      @(negedge clk);
      rx_data = stream[i];
      rx_done = 1'b1;
    end
    @(negedge clk);
    rx_done = 1'b0;
    idle(3);
    expect_write(32'd0, 32'h0A0B0C0D);
    expect_write(32'd4, 32'h12345678);
    expect_write(32'd8, HALT);
    verify_a("b2b");
    verify_b("b2b");
    check("b2b_overlap", 64'(ovl_a), 64'd2);
    check("b2b_count", 64'(ifa.o_inst_count), 64'd3);
    end_case();

    // Reset in the middle of a word
    do_reset();
    send_byte(8'h4C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check("midrst_nwr", 64'(wq_a.size()), 64'd0);
    send_byte(8'h4C);
    send_word(32'h01020304);
    send_word(HALT);
    idle(3);
    expect_write(32'd0, 32'h01020304);
    expect_write(32'd4, HALT);
    verify_a("midrst");
    end_case();

    // Reload after DONE without reset
    check("reload_pre_done", 64'(ifa.o_load_done), 64'd1);
    send_byte(8'h4C);
    check("reload_done_drop", 64'(ifa.o_load_done), 64'd0);
    check("reload_busy", 64'(ifa.o_busy), 64'd1);
    send_word(HALT);
    idle(3);
    expect_write(32'd0, HALT);
    verify_a("reload");
    check("reload_count", 64'(ifa.o_inst_count), 64'd1);
    check("reload_done",  64'(ifa.o_load_done), 64'd1);
    end_case();

    check("no_double_a", 64'(dbl_a), 64'd0);
    check("no_double_b", 64'(dbl_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
